key_schedule_gen: RTL and testbench
===================================

KEY_SCHEDULE_GEN -- requirements
Module: key_schedule_gen

Interface
REQ-001 SHALL have port Clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of Clk.
REQ-003 SHALL have port Start, input, 1 bit: request to generate a new 16-round key sequence.
REQ-004 SHALL have port C0, input, 64 bits: left key half from the upstream key register.
REQ-005 SHALL have port D0, input, 64 bits: right key half from the upstream key register.
REQ-006 SHALL have port Round_key, output, 96 bits: current compressed round subkey.
REQ-007 SHALL have port Round_num, output, 5 bits: round index of Round_key (1..16), 0 when no key is valid.
REQ-008 SHALL have port Key_valid, output, 1 bit: Round_key and Round_num are valid this cycle.
REQ-009 SHALL have port Busy, output, 1 bit: a sequence is in progress and Start is ignored.
REQ-010 SHALL have port Done, output, 1 bit: one-cycle pulse after round 16.

Function
REQ-011 SHALL implement FSM states IDLE, ROUND and DONE; all outputs SHALL be registered.
REQ-012 IDLE with Start=1 at an edge: SHALL latch C0 into internal register C and D0 into internal register D, set the round counter to 1, and go to ROUND with Busy=1.
REQ-013 IDLE with Start=0: SHALL hold state; Key_valid=0, Round_num=0, Busy=0.
REQ-014 At each ROUND edge with counter r, C and D SHALL each rotate left by S(r); S(r)=1 for r in {1,2,9,16}, S(r)=2 otherwise (cumulative 28 after round 16).
REQ-015 At the same edge, SHALL register Round_key={C_rot[63:16], D_rot[63:16]} from the post-rotation values, set Round_num=r and Key_valid=1.
REQ-016 Key_valid SHALL be 1 for exactly 16 consecutive cycles per sequence, with Round_num 1,2,...,16 and no gaps.
REQ-017 After the round-16 edge, the next edge SHALL go to DONE: Done=1, Key_valid=0, Round_num=0, Busy=1; the edge after that SHALL return to IDLE with Done=0 and Busy=0.
REQ-018 Latency: Start sampled at edge k gives the round-1 key after edge k+1, the round-16 key after edge k+16, and Done after edge k+17.
REQ-019 Start asserted in ROUND or DONE SHALL be ignored; it SHALL NOT restart the sequence or alter C/D.
REQ-020 C0/D0 SHALL be sampled only at the accepting edge; later input changes SHALL NOT affect the running sequence.
REQ-021 Start held high continuously SHALL start a new sequence at the first IDLE edge after Done, giving back-to-back sequences 18 cycles apart.
REQ-022 The round counter SHALL be 5 bits, SHALL never exceed 16, and SHALL NOT wrap.

Reset
REQ-023 Reset=1 at an edge SHALL force IDLE, C=0, D=0, counter=0, Round_key=0, Round_num=0, Key_valid=0, Busy=0, Done=0.
REQ-024 Reset SHALL take priority over Start and over any FSM transition, including mid-sequence; no further Key_valid or Done pulse SHALL occur for the aborted sequence.
REQ-025 The first Start accepted after Reset is released SHALL behave exactly as in REQ-012 to REQ-018.

Verification
REQ-026 C0=64'h0001_0000_0000_0000, D0=0, Start pulse -> round 1 Round_key={48'h0002_0000_0000,48'h0}; round 2 {48'h0004_0000_0000,48'h0}; round 3 {48'h0010_0000_0000,48'h0}.
REQ-027 Same stimulus -> round 16 internal C=64'h0000_0000_0000_1000 (C0 rotated left 28), Round_key=96'h0; Done=1 exactly one cycle later, then Busy=0.
REQ-028 C0=0, D0=64'h8000_0000_0000_0000 -> round 1 D_rot=64'h1, Round_key=96'h0; round 3 D_rot=64'h8 (lower 48 bits of Round_key=0); Key_valid high for 16 cycles with Round_num=1..16.
REQ-029 Start re-pulsed at round 5 with different C0/D0 -> ignored; the sequence completes with the original key and Done occurs 17 cycles after the first Start.
REQ-030 Reset asserted during round 8 -> next cycle all outputs 0 and state IDLE; a new Start then gives the round-1 key one cycle later.
REQ-031 Start held at 1 -> Done pulses 18 cycles apart; Key_valid=0 during each Done cycle and during the following IDLE cycle.

Source files
------------

// File: rtl/key_schedule_gen_if.sv
// Handshake and key bus between the upstream key register / consumer and
// the key schedule generator.
interface key_schedule_gen_if;
  logic        Start;
  logic [63:0] C0;
  logic [63:0] D0;
  logic [95:0] Round_key;
  logic [4:0]  Round_num;
  logic        Key_valid;
  logic        Busy;
  logic        Done;

  modport master (
    output Start, C0, D0,
    input  Round_key, Round_num, Key_valid, Busy, Done
  );

  modport slave (
    input  Start, C0, D0,
    output Round_key, Round_num, Key_valid, Busy, Done
  );
endinterface

// File: rtl/key_schedule_gen.sv
// 16-round key schedule: rotates latched key halves C/D by the round shift
// schedule and emits one compressed 96-bit subkey per cycle.
module key_schedule_gen (
  input  logic                Clk,
  input  logic                Reset,
  key_schedule_gen_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t      state, state_nxt;
  logic [63:0] c_reg, d_reg, c_nxt, d_nxt, c_rot, d_rot;
  logic [4:0]  cnt, cnt_nxt;
  logic [95:0] key_q, key_nxt;
  logic [4:0]  num_q, num_nxt;
  logic        kv_q, kv_nxt;
  logic        busy_q, busy_nxt;
  logic        done_q, done_nxt;

  // Rounds 1, 2, 9 and 16 shift by one; all others by two.
  function automatic logic shift_two(input logic [4:0] r);
    return !(r == 5'd1 || r == 5'd2 || r == 5'd9 || r == 5'd16);
  endfunction

  function automatic logic [63:0] rotl(input logic [63:0] v, input logic two);
    return two ? {v[61:0], v[63:62]} : {v[62:0], v[63]};
  endfunction

  assign c_rot = rotl(c_reg, shift_two(cnt));
  assign d_rot = rotl(d_reg, shift_two(cnt));

  always_comb begin
    state_nxt = state;
    c_nxt     = c_reg;
    d_nxt     = d_reg;
    cnt_nxt   = cnt;
    key_nxt   = '0;
    num_nxt   = '0;
    kv_nxt    = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Start) begin
          c_nxt     = bus.C0;
          d_nxt     = bus.D0;
          cnt_nxt   = 5'd1;
          busy_nxt  = 1'b1;
          state_nxt = ROUND;
        end
      end
      ROUND: begin
        c_nxt    = c_rot;
        d_nxt    = d_rot;
        key_nxt  = {c_rot[63:16], d_rot[63:16]};
        num_nxt  = cnt;
        kv_nxt   = 1'b1;
        busy_nxt = 1'b1;
        if (cnt == 5'd16) begin
          cnt_nxt   = 5'd0;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + 5'd1;
        end
      end
      // The Done pulse is registered on this edge, so the very next edge is
      // already IDLE and can accept a held Start (18-cycle repeat).
      DONE: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      c_reg  <= '0;
      d_reg  <= '0;
      cnt    <= '0;
      key_q  <= '0;
      num_q  <= '0;
      kv_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      c_reg  <= c_nxt;
      d_reg  <= d_nxt;
      cnt    <= cnt_nxt;
      key_q  <= key_nxt;
      num_q  <= num_nxt;
      kv_q   <= kv_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
    end
  end

  assign bus.Round_key = key_q;
  assign bus.Round_num = num_q;
  assign bus.Key_valid = kv_q;
  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;

endmodule

// File: tb/tb_key_schedule_gen.sv
// Directed/randomized bench for key_schedule_gen against a cumulative-shift
// reference model.
module tb_key_schedule_gen;

  logic Clk = 1'b0;
  logic Reset;
  int   vectors = 0;
  int   errors  = 0;

  key_schedule_gen_if bus ();

  key_schedule_gen dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // Round key after round r: each half rotated left by the running sum of shifts.
  function automatic logic [95:0] ref_key(input logic [63:0] c0, input logic [63:0] d0,
                                          input int r);
    int sh = 0;
    logic [63:0] c, d;
    for (int i = 1; i <= r; i++)
      sh += (i == 1 || i == 2 || i == 9 || i == 16) ? 1 : 2;
    c = (c0 << sh) | (c0 >> (64 - sh));
    d = (d0 << sh) | (d0 >> (64 - sh));
    return {c[63:16], d[63:16]};
  endfunction

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic busy_exp);
    check({tag, "_kv"},   96'(bus.Key_valid), 96'(0));
    check({tag, "_num"},  96'(bus.Round_num), 96'(0));
    check({tag, "_key"},  bus.Round_key,      96'(0));
    check({tag, "_busy"}, 96'(bus.Busy),      96'(busy_exp));
    check({tag, "_done"}, 96'(bus.Done),      96'(0));
  endtask

  // One full sequence. accepted: Start was already taken at the previous edge.
  // hold: keep Start high and present c_n/d_n for the following sequence.
  task automatic run_seq(input logic [63:0] c0, input logic [63:0] d0,
                         input bit accepted, input bit hold,
                         input int abort_at, input int repulse_at,
                         input logic [63:0] c_n, input logic [63:0] d_n);
    if (!accepted) begin
      bus.C0 = c0; bus.D0 = d0; bus.Start = 1'b1;
      step();
      check_idle("accept", 1'b1);
    end
    bus.Start = hold;
    for (int r = 1; r <= 16; r++) begin
      bus.C0 = {$urandom, $urandom};
      bus.D0 = {$urandom, $urandom};
      step();
      check($sformatf("r%0d_kv", r),   96'(bus.Key_valid), 96'(1));
      check($sformatf("r%0d_num", r),  96'(bus.Round_num), 96'(r));
      check($sformatf("r%0d_key", r),  bus.Round_key,      ref_key(c0, d0, r));
      check($sformatf("r%0d_busy", r), 96'(bus.Busy),      96'(1));
      check($sformatf("r%0d_done", r), 96'(bus.Done),      96'(0));
      bus.Start = (r == repulse_at) ? 1'b1 : hold;
      if (r == abort_at) begin
        Reset = 1'b1;
        step();
        check_idle("abort", 1'b0);
        Reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
          step();
          check($sformatf("post_abort%0d_kv", k),   96'(bus.Key_valid), 96'(0));
          check($sformatf("post_abort%0d_done", k), 96'(bus.Done),      96'(0));
        end
        return;
      end
    end
    if (hold) begin
      bus.C0 = c_n; bus.D0 = d_n;
    end
    step();
    check("done_pulse", 96'(bus.Done),      96'(1));
    check("done_kv",    96'(bus.Key_valid), 96'(0));
    check("done_num",   96'(bus.Round_num), 96'(0));
    check("done_busy",  96'(bus.Busy),      96'(1));
    step();
    check_idle("after_done", hold);
  endtask

  initial begin
    logic [63:0] a, b, c;
    bus.Start = 1'b0;
    bus.C0 = '0;
    bus.D0 = '0;
    Reset = 1'b1;
    step();
    step();
    check_idle("reset", 1'b0);

    // Reset wins over Start.
    bus.Start = 1'b1;
    bus.C0 = {$urandom, $urandom};
    step();
    check_idle("reset_prio", 1'b0);
    Reset = 1'b0;
    bus.Start = 1'b0;
    step();
    check_idle("idle", 1'b0);

    run_seq(64'h0001_0000_0000_0000, 64'h0, 0, 0, 0, 0, '0, '0);
    run_seq(64'h0, 64'h8000_0000_0000_0000, 0, 0, 0, 0, '0, '0);
    run_seq({$urandom, $urandom}, {$urandom, $urandom}, 0, 0, 0, 5, '0, '0);
    run_seq({$urandom, $urandom}, {$urandom, $urandom}, 0, 0, 8, 0, '0, '0);
    run_seq({$urandom, $urandom}, {$urandom, $urandom}, 0, 0, 0, 0, '0, '0);

    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    c = {$urandom, $urandom};
    run_seq(a, {$urandom, $urandom}, 0, 1, 0, 0, b, c);
    run_seq(b, c, 1, 1, 0, 0, c, a);
    run_seq(c, a, 1, 0, 0, 0, '0, '0);

    for (int n = 0; n < 4; n++)
      run_seq({$urandom, $urandom}, {$urandom, $urandom}, 0, 0, 0, 0, '0, '0);

    step();
    check_idle("final", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
